ibex_instr_bus_arbiter: RTL

- Shares one instruction-side memory port between two hosts.
- Host 0 is the prefetch buffer's fetch interface. Host 1 is a secondary requester, e.g. the debug-module program-buffer or a scrub engine.
- Uses the same req/gnt/rvalid pipelined protocol on every side. Tracks up to MaxOutstanding in-order transactions and routes each response back to the host that issued it.
- Sits between the prefetch buffer's instr_* port and the core's instruction bus.

---
 rtl/ibex_instr_bus_arbiter_pkg.sv | 15 +
 rtl/ibex_instr_arb_id_fifo.sv | 45 ++++
 rtl/ibex_instr_bus_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/ibex_instr_bus_arbiter_pkg.sv
// Shared types for the instruction-bus arbiter: the host id and the width of
// the outstanding-transaction counter.
package ibex_instr_bus_arbiter_pkg;

  typedef enum logic {
    INSTR_HOST_FETCH = 1'b0,
    INSTR_HOST_AUX   = 1'b1
  } instr_host_e;

  // Width needed to count 0..n inclusive
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ibex_instr_arb_id_fifo.sv
// In-order FIFO of host ids, one entry per granted-but-unanswered transaction.
// The occupancy counter doubles as the arbiter's outstanding count.
module ibex_instr_arb_id_fifo
  import ibex_instr_bus_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = cnt_width(Depth)
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            push,
  input  logic            push_id,
  input  logic            pop,
  output logic            head,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  instr_host_e     mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;

  // Pointers wrap at Depth, which need not be a power of two
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= instr_host_e'(push_id);
        wptr_q        <= nxt(wptr_q);
      end
      if (pop) rptr_q <= nxt(rptr_q);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  assign head = mem_q[rptr_q];

endmodule

// File: rtl/ibex_instr_bus_arbiter.sv
// Shares one req/gnt/rvalid instruction port between the fetch host and an
// auxiliary host; responses are routed back in order via an id FIFO.
module ibex_instr_bus_arbiter
  import ibex_instr_bus_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter bit          CheckProtocol  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 h0_req_i,
  input  logic [AddrWidth-1:0] h0_addr_i,
  output logic                 h0_gnt_o,
  output logic                 h0_rvalid_o,
  input  logic                 h1_req_i,
  input  logic [AddrWidth-1:0] h1_addr_i,
  output logic                 h1_gnt_o,
  output logic                 h1_rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic                 dev_req_o,
  output logic [AddrWidth-1:0] dev_addr_o,
  input  logic                 dev_gnt_i,
  input  logic                 dev_rvalid_i,
  input  logic [DataWidth-1:0] dev_rdata_i,
  input  logic                 dev_err_i,
  output logic                 busy_o
);

  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  logic            lock_q;
  instr_host_e     owner_q, rr_last_q, winner;
  logic            win_req, can_issue, grant, pop, head;
  logic [CntW-1:0] count;
  logic            stray_rvalid, owner_dropped;

  // A presented-but-ungranted request stays selected until granted
  always_comb begin
    winner = INSTR_HOST_FETCH;
    if (lock_q)                    winner = owner_q;
    else if (h0_req_i && h1_req_i) winner = (rr_last_q == INSTR_HOST_FETCH) ? INSTR_HOST_AUX
                                                                            : INSTR_HOST_FETCH;
    else if (h1_req_i)             winner = INSTR_HOST_AUX;
  end

  assign win_req   = (winner == INSTR_HOST_AUX) ? h1_req_i : h0_req_i;
  assign can_issue = (count < CntW'(MaxOutstanding));

  assign dev_req_o  = ~rst_i & can_issue & win_req;
  assign dev_addr_o = rst_i ? '0 : ((winner == INSTR_HOST_AUX) ? h1_addr_i : h0_addr_i);
  assign grant      = dev_req_o & dev_gnt_i;
  assign h0_gnt_o   = grant & (winner == INSTR_HOST_FETCH);
  assign h1_gnt_o   = grant & (winner == INSTR_HOST_AUX);

  // Responses with nothing outstanding are dropped rather than misrouted
  assign pop          = ~rst_i & dev_rvalid_i & (count != '0);
  assign h0_rvalid_o  = pop & ~head;
  assign h1_rvalid_o  = pop & head;
  assign rdata_o      = dev_rdata_i;
  assign err_o        = dev_err_i;
  assign busy_o       = ~rst_i & (dev_req_o | lock_q | (count != '0));

  assign stray_rvalid  = ~rst_i & dev_rvalid_i & (count == '0);
  assign owner_dropped = ~rst_i & lock_q & ~win_req;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q    <= 1'b0;
      owner_q   <= INSTR_HOST_FETCH;
      rr_last_q <= INSTR_HOST_AUX;
    end else begin
      if (dev_req_o && !dev_gnt_i) begin
        lock_q  <= 1'b1;
        owner_q <= winner;
      end else if (dev_gnt_i || !win_req) begin
        lock_q  <= 1'b0;
      end
      if (grant) rr_last_q <= winner;
    end
  end

  ibex_instr_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .CntW  (CntW)
  ) u_id_fifo (
    .clk     (clk_i),
    .clear   (rst_i),
    .push    (grant),
    .push_id (winner),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  if (CheckProtocol) begin : g_chk
    a_stray_rvalid:  assert property (@(posedge clk_i) !stray_rvalid);
    a_owner_dropped: assert property (@(posedge clk_i) !owner_dropped);
  end

endmodule
